ppt_match: RTL
==============

# ppt_match

Match controller for the rock-paper-scissors judge (`ppt`). It collects one move from each player with a valid/ready handshake and drives the two 2-bit move codes into the judge. It then reads back the judge's `j1_w`/`j2_w` verdict, keeps the round score and declares the match winner once one player reaches `WINS` round wins. It sits on the opposite side of the judge interface: it produces `j1`/`j2` and consumes `j1_w`/`j2_w`.

## Interface
- `WINS`, 3: round wins needed to take the match (1..2^SCORE_W-1).
- `SCORE_W`, 3: width of score counters.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin new match; honoured only in IDLE or DONE.
- `p1_valid` / `p2_valid`  in  1  player move offered.
- `p1_move` / `p2_move`  in  2  move code: 01 rock, 10 paper, 11 scissors, 00 invalid.
- `p1_ready` / `p2_ready`  out  1  controller will accept that player's move this cycle.
- `j1` / `j2`  out  2  move codes to judge; 00 except in DRIVE.
- `j1_w` / `j2_w`  in  1  judge verdict, combinational from `j1`/`j2`.
- `score1` / `score2`  out  SCORE_W  round wins this match.
- `round_done`  out  1  one-cycle pulse per scored round.
- `tie`  out  1  one-cycle pulse, coincident with `round_done`, for a drawn round.
- `err`  out  1  one-cycle pulse on judge verdict 00/00.
- `busy`  out  1  high in COLLECT, DRIVE, SCORE.
- `match_done`  out  1  level, high in DONE.
- `winner`  out  2  01 player 1, 10 player 2, 00 none; valid while `match_done`.

## Operation
- States: IDLE, COLLECT, DRIVE, SCORE, DONE.
- Reset: state IDLE. All outputs 0: ready, `j1`/`j2`, scores, pulses, `busy`, `match_done`, `winner`. Move latches cleared.
- IDLE: `start` clears scores and goes to COLLECT.
- COLLECT:
  - `pN_ready` = 1 while player N's move is not yet latched.
  - A move is accepted on an edge with `pN_valid & pN_ready & pN_move != 00`. The code is latched and `pN_ready` drops.
  - A move of 00 is never accepted; `pN_ready` stays high.
  - Both players may be accepted on the same edge.
  - When both are latched (including the same edge), the next state is DRIVE.
- DRIVE (exactly 1 cycle):
  - `j1`/`j2` are registered outputs and equal the latched codes for this cycle only.
  - The verdict is sampled at the end of the cycle.
- SCORE (exactly 1 cycle): decoded from the sampled verdict.
  - 1/0: `score1`+1.
  - 0/1: `score2`+1.
  - 1/1: `tie`=1, scores unchanged.
  - 0/0: `err`=1, scores unchanged, round replayed.
  - `round_done`=1 for every verdict except 0/0.
  - Latches are cleared. If either score == `WINS`, go to DONE; otherwise go to COLLECT.
- DONE:
  - `match_done`=1; `winner` is set from whichever score equals `WINS`.
  - Ready outputs stay 0, so moves are ignored.
  - `start` clears scores, `winner` and `match_done` on the same edge and goes to COLLECT.
- `start` in COLLECT/DRIVE/SCORE: ignored.
- Scores never exceed `WINS`, so no wrap-around.

## Timing
- Last move accepted at edge k. DRIVE is cycle k+1, with `j1`/`j2` valid. SCORE is cycle k+2, with updated scores and pulses visible. Next state from edge k+3.
- Round latency after the second acceptance: 2 cycles to the score update.
- `match_done` rises in cycle k+3 when the deciding round scores at k+2.
- `rst` overrides everything, including `start` and mid-round states. Outputs reach reset values in the cycle after the reset edge, and any partial round is discarded.
- `p1_ready`/`p2_ready` are registered. A move that is held valid after acceptance is not re-accepted.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs -> all outputs 0, state IDLE; `p1_valid` with no `start` -> `p1_ready` stays 0.
- Single round: `start`, then p1=01 and p2=11 in the same cycle, judge model returns 1/0 -> `j1`=01 and `j2`=11 for exactly one cycle; one cycle later `score1`=1, `score2`=0, `round_done`=1, `tie`=0.
- Staggered tie: p1=10 accepted, p2=10 three cycles later, judge 1/1 -> `p1_ready` low during the wait; `tie`=`round_done`=1; scores stay 0/0; back to COLLECT with both ready.
- Match end: p2 wins 3 rounds -> `score2`=3, `match_done`=1, `winner`=10, `busy`=0. Further valid moves are not accepted. `start` -> scores 0, COLLECT.
- Invalid and error: `p1_move`=00 with valid -> not accepted, ready high. Judge forced to 0/0 -> `err` pulse, no `round_done`, scores unchanged, round replayed.
- Reset mid-round: `rst` during DRIVE -> next cycle `j1`=`j2`=00, scores 0, IDLE; `start` while busy has no effect.

Source files
------------

// File: rtl/ppt_match.sv
// Match controller for the rock-paper-scissors judge: collects both moves,
// drives them to the judge for one cycle, scores the verdict, declares a winner.
module ppt_match #(
  parameter int unsigned WINS    = 3,
  parameter int unsigned SCORE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               p1_valid,
  input  logic               p2_valid,
  input  logic [1:0]         p1_move,
  input  logic [1:0]         p2_move,
  output logic               p1_ready,
  output logic               p2_ready,
  output logic [1:0]         j1,
  output logic [1:0]         j2,
  input  logic               j1_w,
  input  logic               j2_w,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               round_done,
  output logic               tie,
  output logic               err,
  output logic               busy,
  output logic               match_done,
  output logic [1:0]         winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DRIVE,
    S_SCORE,
    S_DONE
  } state_e;

  localparam logic [SCORE_W-1:0] WINS_C = SCORE_W'(WINS);

  state_e             state_q, state_d;
  logic [1:0]         mv1_q, mv1_d, mv2_q, mv2_d;
  logic [1:0]         j1_q, j1_d, j2_q, j2_d;
  logic [1:0]         winner_q, winner_d;
  logic               rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic               round_done_q, round_done_d;
  logic               tie_q, tie_d, err_q, err_d;
  logic               busy_q, busy_d, match_done_q, match_done_d;

  always_comb begin
    state_d      = state_q;
    mv1_d        = mv1_q;
    mv2_d        = mv2_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    winner_d     = winner_q;
    round_done_d = 1'b0;
    tie_d        = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          score1_d = '0;
          score2_d = '0;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A latched move is never 00, so a nonzero latch doubles as its valid flag
        if (p1_valid && rdy1_q && (p1_move != 2'b00)) mv1_d = p1_move;
        if (p2_valid && rdy2_q && (p2_move != 2'b00)) mv2_d = p2_move;
        if ((mv1_d != 2'b00) && (mv2_d != 2'b00)) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        state_d = S_SCORE;
        unique case ({j1_w, j2_w})
          2'b10: begin
            score1_d     = score1_q + SCORE_W'(1);
            round_done_d = 1'b1;
          end
          2'b01: begin
            score2_d     = score2_q + SCORE_W'(1);
            round_done_d = 1'b1;
          end
          2'b11: begin
            tie_d        = 1'b1;
            round_done_d = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_SCORE: begin
        mv1_d = '0;
        mv2_d = '0;
        if (score1_q == WINS_C) begin
          winner_d = 2'b01;
          state_d  = S_DONE;
        end else if (score2_q == WINS_C) begin
          winner_d = 2'b10;
          state_d  = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        if (start) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = '0;
          state_d  = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it
    rdy1_d       = (state_d == S_COLLECT) && (mv1_d == 2'b00);
    rdy2_d       = (state_d == S_COLLECT) && (mv2_d == 2'b00);
    j1_d         = (state_d == S_DRIVE) ? mv1_d : 2'b00;
    j2_d         = (state_d == S_DRIVE) ? mv2_d : 2'b00;
    busy_d       = (state_d == S_COLLECT) || (state_d == S_DRIVE) || (state_d == S_SCORE);
    match_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mv1_q        <= '0;
      mv2_q        <= '0;
      j1_q         <= '0;
      j2_q         <= '0;
      winner_q     <= '0;
      rdy1_q       <= 1'b0;
      rdy2_q       <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      round_done_q <= 1'b0;
      tie_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      match_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mv1_q        <= mv1_d;
      mv2_q        <= mv2_d;
      j1_q         <= j1_d;
      j2_q         <= j2_d;
      winner_q     <= winner_d;
      rdy1_q       <= rdy1_d;
      rdy2_q       <= rdy2_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      round_done_q <= round_done_d;
      tie_q        <= tie_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      match_done_q <= match_done_d;
    end
  end

  assign p1_ready   = rdy1_q;
  assign p2_ready   = rdy2_q;
  assign j1         = j1_q;
  assign j2         = j2_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign round_done = round_done_q;
  assign tie        = tie_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign match_done = match_done_q;
  assign winner     = winner_q;

endmodule
